// File: rtl/spu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : spu_pkg
// Brief   : Shared widths, even-pipe entry type and forwarding codes.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package spu_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 128;

  localparam logic [0:4] FWD_NONE  = 5'b00000;
  localparam logic [0:4] FWD_DATAE = 5'b01010;
  localparam logic [0:4] FWD_DATAO = 5'b11000;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [0:ADDR_W-1] rt;
    logic [0:DATA_W-1] data;
    logic              ready;
  } even_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_hazard_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : wb_hazard_cmp
// Brief   : Per-source RAW match against the even pipe: stall and forward code.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module wb_hazard_cmp #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7
) (
  input  logic              [0:ADDR_W-1] src,
  input  logic                           issue_wr,
  input  logic              [0:ADDR_W-1] issue_rt,
  input  logic              [1:DEPTH]    stage_wr,
  input  logic              [0:ADDR_W-1] stage_rt [1:DEPTH],
  input  logic                           fwd_ready,
  output logic                           stall,
  output logic              [0:4]        fwd_code
);
  import spu_pkg::*;

  logic w_young;
  logic w_fwd;
  logic w_wb;

  always_comb begin
    w_young = issue_wr && (issue_rt == src);
    for (int s = 1; s <= DEPTH - 2; s++) begin
      if (stage_wr[s] && (stage_rt[s] == src)) begin
        w_young = 1'b1;
      end
    end
    w_fwd = stage_wr[DEPTH-1] && (stage_rt[DEPTH-1] == src);
    // The write-back entry commits on the same edge the register file reads.
    w_wb  = stage_wr[DEPTH] && (stage_rt[DEPTH] == src);
  end

  assign stall    = w_young | w_wb | (w_fwd & ~fwd_ready);
  assign fwd_code = (w_fwd & fwd_ready & ~w_young) ? FWD_DATAE : FWD_NONE;

endmodule
`default_nettype wire

// File: rtl/even_writeback_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : even_writeback_pipe
// Brief   : Even-pipe in-flight tracker aligning unit results to write-back,
//           with operand forwarding codes and RAW stall for the next issue.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module even_writeback_pipe #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic              WrEnIn,
  input  logic [0:ADDR_W-1] RTIn,
  input  logic              ResultValid,
  input  logic [0:2]        ResultStage,
  input  logic [0:DATA_W-1] ResultData,
  input  logic [0:ADDR_W-1] RAE,
  input  logic [0:ADDR_W-1] RBE,
  input  logic [0:ADDR_W-1] RCE,
  output logic              WBE,
  output logic [0:ADDR_W-1] AddressEi,
  output logic [0:DATA_W-1] DataE,
  output logic [0:4]        ForwardE1,
  output logic [0:4]        ForwardE2,
  output logic [0:4]        ForwardE3,
  output logic              StallE,
  output logic              DataMissing
);
  import spu_pkg::*;

  // ADDR_W/DATA_W must match the spu_pkg widths used by even_entry_t.
  even_entry_t       r_stage [1:DEPTH];
  even_entry_t       w_next  [1:DEPTH];
  logic [1:DEPTH]    w_cap;
  logic              w_issue;
  logic              w_bad_result;
  logic              w_retire_missing;

  logic [1:DEPTH]    w_stage_wr;
  logic [0:ADDR_W-1] w_stage_rt [1:DEPTH];
  logic [0:ADDR_W-1] w_src      [0:2];
  logic [0:2]        w_stall;
  logic [0:4]        w_fwd      [0:2];

  assign w_issue = ValidIn & ~Flush;

  always_comb begin
    w_cap = '0;
    for (int s = 1; s <= DEPTH; s++) begin
      w_cap[s] = ResultValid && r_stage[s].valid && ({1'b0, ResultStage} == 4'(s));
    end
  end

  assign w_bad_result     = ResultValid & ~(|w_cap);
  assign w_retire_missing = r_stage[DEPTH].valid & r_stage[DEPTH].wr & ~r_stage[DEPTH].ready;

  // Next-state: everything shifts one stage; a captured result rides along.
  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      w_next[s] = '0;
    end
    if (w_issue) begin
      w_next[1].valid = 1'b1;
      w_next[1].wr    = WrEnIn;
      w_next[1].rt    = RTIn;
    end
    if (!Flush) begin
      for (int s = 2; s <= DEPTH; s++) begin
        w_next[s] = r_stage[s-1];
        if (w_cap[s-1]) begin
          w_next[s].data  = ResultData;
          w_next[s].ready = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      w_stage_wr[s] = r_stage[s].valid & r_stage[s].wr;
      w_stage_rt[s] = r_stage[s].rt;
    end
  end

  assign w_src[0] = RAE;
  assign w_src[1] = RBE;
  assign w_src[2] = RCE;

  for (genvar i = 0; i < 3; i++) begin : g_src
    wb_hazard_cmp #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_cmp (
      .src       (w_src[i]),
      .issue_wr  (ValidIn & WrEnIn),
      .issue_rt  (RTIn),
      .stage_wr  (w_stage_wr),
      .stage_rt  (w_stage_rt),
      .fwd_ready (r_stage[DEPTH-1].ready),
      .stall     (w_stall[i]),
      .fwd_code  (w_fwd[i])
    );
  end

  assign StallE = |w_stall;

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_stage[s] <= '0;
      end
      ForwardE1   <= FWD_NONE;
      ForwardE2   <= FWD_NONE;
      ForwardE3   <= FWD_NONE;
      DataMissing <= 1'b0;
    end else begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_stage[s] <= w_next[s];
      end
      if (Flush) begin
        ForwardE1 <= FWD_NONE;
        ForwardE2 <= FWD_NONE;
        ForwardE3 <= FWD_NONE;
      end else begin
        ForwardE1 <= w_fwd[0];
        ForwardE2 <= w_fwd[1];
        ForwardE3 <= w_fwd[2];
      end
      if (w_bad_result | w_retire_missing) begin
        DataMissing <= 1'b1;
      end
    end
  end

  assign WBE       = r_stage[DEPTH].valid & r_stage[DEPTH].wr;
  assign AddressEi = r_stage[DEPTH].rt;
  assign DataE     = r_stage[DEPTH].data;

endmodule
`default_nettype wire
